vga_stream_sink: RTL

//  VGA-side endpoint of the pixel request/data interface that feeds the colour-adjust/complexion

---
 rtl/vga_stream_sink.sv | 84 ++++++++
 1 files changed

// File: rtl/vga_stream_sink.sv
// vga_stream_sink: 640x480@60 raster generator that requests pixels upstream and drives registered VGA pins,
// with sync/blank delayed to line up with the returned RGB.
module vga_stream_sink #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int REQ_LEAD = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        oRequest,
    input  logic [9:0]  iRed,
    input  logic [9:0]  iGreen,
    input  logic [9:0]  iBlue,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        oFrameStart,
    output logic [15:0] oFrameCnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic started, h_end, v_end, wrap, act, hs_raw, vs_raw;
    // {act, hs, vs} per stage; the last stage lines up with the returning RGB
    logic [REQ_LEAD:0][2:0] sr;

    always_comb begin
        h_end  = h == HW'(H_TOTAL - 1);
        v_end  = v == VW'(V_TOTAL - 1);
        wrap   = started && h_end && v_end;
        act    = started && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
        hs_raw = !((h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC)));
        vs_raw = !((v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC)));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h           <= '0;
            v           <= '0;
            started     <= 1'b0;
            oRequest    <= 1'b0;
            sr          <= {(REQ_LEAD + 1){3'b011}};
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            oFrameStart <= 1'b0;
            oFrameCnt   <= '0;
        end else begin
            // counters hold (0,0) for the first edge after release, and that (0,0) is not a frame wrap
            started <= 1'b1;
            if (started) begin
                h <= h_end ? '0 : h + 1'b1;
                if (h_end)
                    v <= v_end ? '0 : v + 1'b1;
            end
            oRequest    <= act;
            sr          <= {sr[REQ_LEAD-1:0], {act, hs_raw, vs_raw}};
            VGA_R       <= sr[REQ_LEAD][2] ? iRed   : '0;
            VGA_G       <= sr[REQ_LEAD][2] ? iGreen : '0;
            VGA_B       <= sr[REQ_LEAD][2] ? iBlue  : '0;
            VGA_HS      <= sr[REQ_LEAD][1];
            VGA_VS      <= sr[REQ_LEAD][0];
            VGA_BLANK_N <= sr[REQ_LEAD][2];
            oFrameStart <= wrap;
            oFrameCnt   <= oFrameCnt + 16'(wrap);
        end
    end
endmodule
